// File: rtl/caches_pkg.sv
// rtl/caches_pkg.sv - shared cache/RAM types and arbiter state encoding.
package caches_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_LOAD  = 3'd1,
    D_STORE = 3'd2,
    I_LOAD  = 3'd3,
    ERR     = 3'd4
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - grant watchdog; expired while enabled at TIMEOUT_CYCLES-1.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);
endmodule

// File: rtl/memory_arbiter_ctrl.sv
// rtl/memory_arbiter_ctrl.sv - shares one RAM port between icache fetches and dcache loads/stores.
module memory_arbiter_ctrl
  import caches_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
  parameter bit IFAIR          = 1'b1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     iaddr,
  input  word_t     daddr,
  input  word_t     dstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  input  logic      ramBUSY,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output word_t     ramaddr,
  output word_t     ramstore,
  output logic      ramREN,
  output logic      ramWEN,
  output logic      load_done,
  output logic      store_done,
  output logic      arb_error
);
  arb_state_t state, state_next;
  logic       last_d, last_d_next;
  logic       grant, owner_req, done, expired;

  assign grant = (state == D_LOAD) || (state == D_STORE) || (state == I_LOAD);

  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (state_next != state),
    .enable (grant),
    .expired(expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_next;
      last_d <= last_d_next;
    end
  end

  always_comb begin
    state_next  = state;
    last_d_next = last_d;
    owner_req   = 1'b0;
    done        = 1'b0;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = '0;
    dload       = '0;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    load_done   = 1'b0;
    store_done  = 1'b0;

    if (state == IDLE) begin
      // Fairness: after a data grant a pending fetch jumps ahead of data requests.
      if (IFAIR && last_d && iREN) begin
        state_next  = I_LOAD;
        last_d_next = 1'b0;
      end else if (dWEN) begin
        state_next  = D_STORE;
        last_d_next = 1'b1;
      end else if (dREN) begin
        state_next  = D_LOAD;
        last_d_next = 1'b1;
      end else if (iREN) begin
        state_next  = I_LOAD;
        last_d_next = 1'b0;
      end
    end else if (grant) begin
      owner_req = (state == D_LOAD)  ? dREN :
                  (state == D_STORE) ? dWEN : iREN;
      done      = owner_req && (ramstate == ACCESS) && !ramBUSY;
      ramaddr   = (state == I_LOAD) ? iaddr : daddr;
      ramREN    = owner_req && (state != D_STORE);
      ramWEN    = owner_req && (state == D_STORE);
      if (state == D_STORE) ramstore = dstore;

      // A dropped request aborts the access quietly; completion wins over a same-cycle timeout.
      if (ramstate == ERROR) state_next = ERR;
      else if (!owner_req || done) state_next = IDLE;
      else if (expired) state_next = ERR;

      if (done) begin
        if (state == I_LOAD) begin
          iwait = 1'b0;
          iload = ramload;
        end else if (state == D_LOAD) begin
          dwait     = 1'b0;
          dload     = ramload;
          load_done = 1'b1;
        end else begin
          dwait      = 1'b0;
          store_done = 1'b1;
        end
      end
    end
  end

  assign arb_error = (state == ERR);
endmodule

// File: tb/tb_memory_arbiter_ctrl.sv
// tb/tb_memory_arbiter_ctrl.sv - vector table plus directed sequences for memory_arbiter_ctrl.
module tb_memory_arbiter_ctrl;
  import caches_pkg::*;

  localparam word_t DADDR = 32'h0000_0100;
  localparam word_t IADDR = 32'h0000_0200;
  localparam word_t SDATA = 32'hCAFE_F00D;
  localparam word_t LDATA = 32'hDEAD_BEEF;
  localparam logic [5:0] IDL = 6'b001100;

  logic      CLK, RST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      ramBUSY;
  logic      iwait, dwait, ramREN, ramWEN, load_done, store_done, arb_error;
  word_t     iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  memory_arbiter_ctrl #(.TIMEOUT_CYCLES(64), .IFAIR(1'b1)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .ramload(ramload),
    .ramstate(ramstate), .ramBUSY(ramBUSY), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN), .load_done(load_done),
    .store_done(store_done), .arb_error(arb_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // flags = {ramREN, ramWEN, iwait, dwait, load_done, store_done}
  typedef struct {
    logic       i_ren, d_ren, d_wen;
    ramstate_t  rs;
    logic       busy;
    logic [5:0] flags;
    word_t      addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic i, logic d, logic w, ramstate_t rs, logic b,
                             logic [5:0] f, word_t a);
    vec_t r;
    r.i_ren = i; r.d_ren = d; r.d_wen = w; r.rs = rs; r.busy = b;
    r.flags = f; r.addr = a;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic i, logic d, logic w, ramstate_t rs, logic b);
    iREN = i; dREN = d; dWEN = w; ramstate = rs; ramBUSY = b;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [5:0] f;
    int n;
    RST = 1'b1;
    iaddr = IADDR; daddr = DADDR; dstore = SDATA; ramload = LDATA;
    drive(0, 0, 0, FREE, 0);

    // back-to-back store then fetch, last_d=0 at start
    vecs.push_back(v(1, 0, 1, FREE,   0, IDL,      '0));
    vecs.push_back(v(1, 0, 1, ACCESS, 0, 6'b011001, DADDR));
    vecs.push_back(v(1, 0, 0, FREE,   0, IDL,      '0));
    vecs.push_back(v(1, 0, 0, ACCESS, 0, 6'b100100, IADDR));
    vecs.push_back(v(0, 0, 0, FREE,   0, IDL,      '0));
    // continuous dREN+iREN: D, I, D, I
    for (int k = 0; k < 2; k++) begin
      vecs.push_back(v(1, 1, 0, ACCESS, 0, IDL,       '0));
      vecs.push_back(v(1, 1, 0, ACCESS, 0, 6'b101010, DADDR));
      vecs.push_back(v(1, 1, 0, ACCESS, 0, IDL,       '0));
      vecs.push_back(v(1, 1, 0, ACCESS, 0, 6'b100100, IADDR));
    end
    vecs.push_back(v(0, 0, 0, FREE,   0, IDL,       '0));
    // dcache load with two-cycle RAM latency
    vecs.push_back(v(0, 1, 0, FREE,   0, IDL,       '0));
    vecs.push_back(v(0, 1, 0, BUSY,   1, 6'b101100, DADDR));
    vecs.push_back(v(0, 1, 0, ACCESS, 0, 6'b101010, DADDR));
    vecs.push_back(v(0, 0, 0, ACCESS, 0, IDL,       '0));
    // dWEN+dREN together: store wins
    vecs.push_back(v(0, 1, 1, FREE,   0, IDL,       '0));
    vecs.push_back(v(0, 1, 1, ACCESS, 0, 6'b011001, DADDR));
    vecs.push_back(v(0, 0, 0, FREE,   0, IDL,       '0));
    // last_d=1 now: fetch beats a pending load
    vecs.push_back(v(1, 1, 0, FREE,   0, IDL,       '0));
    vecs.push_back(v(1, 1, 0, ACCESS, 0, 6'b100100, IADDR));
    vecs.push_back(v(0, 0, 0, FREE,   0, IDL,       '0));

    @(negedge CLK); @(negedge CLK); #1;
    chk("reset flags", {ramREN, ramWEN, iwait, dwait, load_done, store_done}, IDL);
    chk("reset ramaddr", ramaddr, '0);
    chk("reset arb_error", arb_error, 0);
    @(negedge CLK);
    RST = 1'b0;

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].i_ren, vecs[i].d_ren, vecs[i].d_wen, vecs[i].rs, vecs[i].busy);
      #1;
      f = vecs[i].flags;
      chk($sformatf("row%0d flags", i),
          {ramREN, ramWEN, iwait, dwait, load_done, store_done}, f);
      chk($sformatf("row%0d ramaddr", i), ramaddr, vecs[i].addr);
      chk($sformatf("row%0d dload", i), dload, (!f[2] && f[5]) ? LDATA : '0);
      chk($sformatf("row%0d iload", i), iload, !f[3] ? LDATA : '0);
      chk($sformatf("row%0d ramstore", i), ramstore, f[4] ? SDATA : '0);
      chk($sformatf("row%0d arb_error", i), arb_error, 0);
    end

    // abort: dREN dropped one cycle after the grant
    @(negedge CLK); drive(0, 1, 0, FREE, 0);
    @(negedge CLK); drive(0, 0, 0, BUSY, 1); #1;
    chk("abort ramREN", ramREN, 0);
    chk("abort dwait", dwait, 1);
    chk("abort load_done", load_done, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); drive(0, 0, 0, ACCESS, 0); #1;
      chk($sformatf("post-abort%0d flags", k),
          {ramREN, ramWEN, iwait, dwait, load_done, store_done}, IDL);
    end

    // timeout: ramstate stuck BUSY
    @(negedge CLK); drive(0, 1, 0, BUSY, 1);
    @(posedge CLK);
    n = 0;
    while (n < 200) begin
      @(negedge CLK); #1;
      if (arb_error) break;
      n++;
    end
    chk("timeout grant cycles", n, 64);
    chk("err ramREN", ramREN, 0);
    chk("err dwait", dwait, 1);
    @(negedge CLK); drive(1, 0, 0, ACCESS, 0);
    repeat (4) @(negedge CLK);
    #1;
    chk("err sticky arb_error", arb_error, 1);
    chk("err iwait", iwait, 1);
    chk("err strobes", {ramREN, ramWEN}, 2'b00);
    @(negedge CLK); RST = 1'b1; drive(0, 0, 0, FREE, 0); #1;
    chk("err cleared by RST", arb_error, 0);
    @(negedge CLK); RST = 1'b0;

    // RAM ERROR state during an icache fetch
    @(negedge CLK); drive(1, 0, 0, FREE, 0);
    @(negedge CLK); drive(1, 0, 0, ERROR, 0); #1;
    chk("ramerr strobe before ERR", ramREN, 1);
    @(negedge CLK); #1;
    chk("ramerr arb_error", arb_error, 1);
    chk("ramerr iwait", iwait, 1);
    @(negedge CLK); RST = 1'b1; drive(0, 0, 0, FREE, 0);
    @(negedge CLK); RST = 1'b0;

    // asynchronous reset in the middle of a dcache load
    @(negedge CLK); drive(0, 1, 0, FREE, 0);
    @(negedge CLK); drive(0, 1, 0, BUSY, 1); #1;
    chk("mid-load ramREN", ramREN, 1);
    #2 RST = 1'b1; #1;
    chk("async rst ramREN", ramREN, 0);
    chk("async rst waits", {iwait, dwait}, 2'b11);
    chk("async rst ramaddr", ramaddr, '0);
    chk("async rst arb_error", arb_error, 0);
    @(negedge CLK); drive(0, 0, 0, FREE, 0);
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK); #1;
    chk("after rst flags", {ramREN, ramWEN, iwait, dwait, load_done, store_done}, IDL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
